// File: rtl/kamus_fetch_pkg.sv
// rtl/kamus_fetch_pkg.sv - shared types and constants for the kamus-v fetch stage
package kamus_fetch_pkg;

  localparam int KAMUS_XLEN  = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    PC_ST,
    J_ST,
    B_ST
  } instr_addr_state_t;

  typedef enum logic [1:0] {
    IDLE_ST,
    REQ_ST,
    WAIT_ST,
    DROP_ST
  } fetch_state_t;

  typedef struct packed {
    logic [KAMUS_XLEN-1:0] pc;
    logic [31:0]           instr;
  } fetch_entry_t;

endpackage

// File: rtl/kamus_fetch_if.sv
// rtl/kamus_fetch_if.sv - L1I request/response and decode handoff signals of the fetch stage
interface kamus_fetch_if #(
  parameter int XLEN = 32
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );

endinterface

// File: rtl/kamus_fetch_fifo.sv
// rtl/kamus_fetch_fifo.sv - synchronous FIFO of fetched {pc, instr} entries with flush
module kamus_fetch_fifo
  import kamus_fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);

  fetch_entry_t      mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // When full, a push is only taken if the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/kamus_fetch.sv
// rtl/kamus_fetch.sv - kamus-v fetch stage; KAMUS_FETCH_MISALIGN_EXC_EN enables the misaligned-target exception
module kamus_fetch
  import kamus_fetch_pkg::*;
#(
  parameter int              XLEN       = KAMUS_XLEN,
  parameter logic [XLEN-1:0] RESET_ADDR = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  kamus_fetch_if.master     bus,
  input  logic              redirect_valid_i,
  input  instr_addr_state_t instr_addr_state_i,
  input  logic              branch_taken_i,
  input  logic [XLEN-1:0]   target_addr_i,
  output logic              misalign_exc_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_t    state;
  fetch_state_t    state_next;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic            redirect_taken;
  logic            hold;
  logic            granted;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic [CW-1:0]   unused_count;
  fetch_entry_t    push_data;
  fetch_entry_t    head;

  assign redirect_taken = redirect_valid_i &&
                          ((instr_addr_state_i == J_ST) ||
                           ((instr_addr_state_i == B_ST) && branch_taken_i));

  assign granted = bus.imem_req && bus.imem_gnt;
  assign push    = (state == WAIT_ST) && bus.imem_rvalid && !redirect_taken;
  assign pop     = bus.instr_valid && bus.instr_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE_ST;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE_ST: state_next = REQ_ST;
      REQ_ST: begin
        if (granted) state_next = redirect_taken ? DROP_ST : WAIT_ST;
      end
      WAIT_ST: begin
        // A response arriving with the redirect is already consumed, so there is nothing left to drop.
        if (bus.imem_rvalid)     state_next = REQ_ST;
        else if (redirect_taken) state_next = DROP_ST;
      end
      DROP_ST: begin
        if (bus.imem_rvalid) state_next = REQ_ST;
      end
      default: state_next = IDLE_ST;
    endcase
  end

  always_comb begin
    bus.imem_req = 1'b0;
    if (state == REQ_ST) bus.imem_req = !full && !hold;
  end

  assign bus.imem_addr = pc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc     <= RESET_ADDR;
      req_pc <= '0;
    end else begin
      if (redirect_taken)  pc <= {target_addr_i[XLEN-1:2], 2'b00};
      else if (granted)    pc <= pc + XLEN'(INSTR_BYTES);
      if (granted)         req_pc <= pc;
    end
  end

`ifdef KAMUS_FETCH_MISALIGN_EXC_EN
  logic misaligned;
  assign misaligned = redirect_taken && (target_addr_i[1:0] != 2'b00);

  // Fetch stays parked after a misaligned target until a later redirect replaces it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold           <= 1'b0;
      misalign_exc_o <= 1'b0;
    end else begin
      misalign_exc_o <= misaligned;
      if (redirect_taken) hold <= misaligned;
    end
  end
`else
  logic unused_low_bits;
  assign unused_low_bits = ^target_addr_i[1:0];
  assign hold            = 1'b0;
  assign misalign_exc_o  = 1'b0;
`endif

  assign push_data.pc    = req_pc;
  assign push_data.instr = bus.imem_rdata;

  kamus_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .flush     (redirect_taken),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (unused_count)
  );

  assign bus.instr_valid = !empty;
  assign bus.instr       = head.instr;
  assign bus.instr_pc    = head.pc;

endmodule
